// File: rtl/mem_line_responder.sv
// mem_line_responder
//   Backing-memory end of the cache line interface. Each accepted 256-bit
//   line read or write is answered with a single-cycle ack_o exactly LATENCY
//   cycles after acceptance. The line array "memory" has no reset and is meant
//   to be preloaded and inspected hierarchically.
//
//   Optional build macro MEM_LINE_RESPONDER_STATS_EN adds internal
//   rd_count / wr_count / max_wait_enable counters. The port list is the same.
//
// Ports:
//   clk_i     clock, rising edge
//   rst_i     synchronous active-high reset
//   addr_i    byte address; line index = addr_i[5 +: log2(DEPTH)]
//   data_i    write line data
//   enable_i  request valid
//   write_i   1 = write, 0 = read (sampled with enable_i)
//   ack_o     one-cycle completion pulse
//   data_o    read line data, valid while ack_o = 1, held otherwise
//
// State | meaning
// IDLE  | waiting for enable_i; a request is latched on the edge it is seen
// WAIT  | counting down the remaining latency; inputs ignored
// ACK   | ack_o high for this single cycle, then back to IDLE
module mem_line_responder #(
    parameter int LATENCY    = 10,
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 512
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  enable_i,
    input  logic                  write_i,
    output logic                  ack_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t                state;
    logic [7:0]            counter;
    logic [IDX_W-1:0]      req_idx;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  req_write;

    logic [DATA_WIDTH-1:0] memory [0:DEPTH-1];

    logic [IDX_W-1:0]      in_idx;
    logic                  addr_unused;

    // Offset-within-line and bits above the array size do not select a line,
    // so larger addresses simply alias.
    assign in_idx      = addr_i[5 +: IDX_W];
    assign addr_unused = ^{addr_i[ADDR_WIDTH-1:5+IDX_W], addr_i[4:0]};

    // The commit happens on the edge that enters ACK. With LATENCY = 1 that is
    // the accepting edge itself, so the live inputs are used instead of the
    // request registers.
    logic                  commit_en;
    logic                  commit_write;
    logic [IDX_W-1:0]      commit_idx;
    logic [DATA_WIDTH-1:0] commit_data;

    always_comb begin
        commit_en    = 1'b0;
        commit_write = req_write;
        commit_idx   = req_idx;
        commit_data  = req_data;
        if (state == IDLE) begin
            commit_en    = enable_i && (LATENCY == 1);
            commit_write = write_i;
            commit_idx   = in_idx;
            commit_data  = data_i;
        end else if (state == WAIT) begin
            commit_en = (counter == 8'd0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            ack_o   <= 1'b0;
            data_o  <= '0;
            counter <= '0;
        end else begin
            ack_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable_i) begin
                        req_idx   <= in_idx;
                        req_data  <= data_i;
                        req_write <= write_i;
                        if (LATENCY == 1) begin
                            state <= ACK;
                            ack_o <= 1'b1;
                        end else begin
                            counter <= 8'(LATENCY - 2);
                            state   <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (counter != 8'd0) begin
                        counter <= counter - 8'd1;
                    end else begin
                        state <= ACK;
                        ack_o <= 1'b1;
                    end
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase

            if (commit_en) begin
                if (commit_write) begin
                    memory[commit_idx] <= commit_data;
                end else begin
                    data_o <= memory[commit_idx];
                end
            end
        end
    end

`ifdef MEM_LINE_RESPONDER_STATS_EN
    logic [31:0] rd_count;
    logic [31:0] wr_count;
    logic [15:0] max_wait_enable;
    logic        after_ack;

    // max_wait_enable counts an unbroken run of ACK->IDLE handoffs where the
    // requester still had enable_i high; any handoff with enable_i low clears it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_count        <= '0;
            wr_count        <= '0;
            max_wait_enable <= '0;
            after_ack       <= 1'b0;
        end else begin
            if (commit_en) begin
                if (commit_write) begin
                    wr_count <= wr_count + 32'd1;
                end else begin
                    rd_count <= rd_count + 32'd1;
                end
            end
            after_ack <= (state == ACK);
            if (state == IDLE && after_ack) begin
                if (!enable_i) begin
                    max_wait_enable <= '0;
                end else if (max_wait_enable != 16'hFFFF) begin
                    max_wait_enable <= max_wait_enable + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: doc/mem_line_responder.md
Name: mem_line_responder

Overview:
- Responder end of the cache-to-memory line interface: accepts 256-bit line read/write requests from the data cache's enable/write/addr request port and answers each one with a single-cycle ack after a fixed latency.
- Sits in the testbench/SoC next to the CPU, in the backing-memory position.
- Holds a line-addressed array that the bench can preload and inspect hierarchically.
- Replaces an ad-hoc memory model with a deterministic, parameterised one.

Parameters:
- LATENCY, 10, cycles from request acceptance to ack_o; legal range 1..255.
- DATA_WIDTH, 256, line width in bits.
- ADDR_WIDTH, 32, byte address width.
- DEPTH, 512, number of lines; power of two.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- addr_i  input  ADDR_WIDTH  byte address; line index = addr_i[5+log2(DEPTH)-1:5]; bits [4:0] and the upper bits are ignored.
- data_i  input  DATA_WIDTH  write line data.
- enable_i  input  1  request valid.
- write_i  input  1  1 = write, 0 = read; sampled with enable_i.
- ack_o  output  1  one-cycle completion pulse.
- data_o  output  DATA_WIDTH  read line data; valid while ack_o = 1.

Behaviour:
- Storage: reg array memory[0:DEPTH-1] of DATA_WIDTH bits. Not cleared by reset; the bench preloads it.
- States: IDLE, WAIT, ACK. State register and counter are 2 bits + 8 bits.
- Reset (rst_i = 1 at an edge):
  - state = IDLE, ack_o = 0, data_o = 0, counter = 0.
  - Any pending request is discarded; its write is not committed.
- IDLE:
  - If enable_i = 1 at an edge: latch addr index, data_i and write_i into request registers.
  - LATENCY = 1: go to ACK. Otherwise: counter = LATENCY-2, go to WAIT.
  - If enable_i = 0: stay in IDLE.
- WAIT:
  - Inputs are ignored; a request completes even if enable_i drops.
  - counter != 0: decrement. counter == 0: go to ACK.
- Commit: on the edge entering ACK:
  - Write: memory[idx] <= latched data. data_o is unchanged.
  - Read: data_o <= memory[idx].
- Latency: request sampled at edge T; ack_o is high for exactly the cycle following edge T+LATENCY-1, i.e. ack visible LATENCY cycles after acceptance.
- ACK:
  - ack_o = 1 for one cycle, then unconditionally go to IDLE with ack_o = 0.
  - The requester must drop enable_i in the cycle after ack. If enable_i is still 1 in IDLE, it is treated as a new request; this is a legal back-to-back case.
- Minimum spacing between acks is LATENCY+1 cycles.
- Read-after-write to the same line returns the new data, because the write commits before the ack.
- data_o holds its last value outside ack cycles.
- Index wrap: addresses at or beyond DEPTH*32 alias modulo DEPTH; no error is raised.

Optional Feature:
- Macro: MEM_LINE_RESPONDER_STATS_EN.
- When defined:
  - Internal 32-bit counters rd_count and wr_count are added. Each increments on the edge entering ACK for its request type; both are cleared by rst_i.
  - A 16-bit max_wait_enable counter is added. It counts consecutive IDLE cycles with enable_i = 1 immediately after an ACK; it is for bench assertions on requester turnaround.
  - The bench reads all three hierarchically. The port list is unchanged.
- When undefined: none of these registers exist, and behaviour is otherwise identical.

Test Plan:
- Reset, then preload memory[1] = 256'h8888_9999_..._0000. Read at addr 0x20 with LATENCY=10, enable_i held until ack → ack_o high exactly 10 cycles after acceptance, data_o = memory[1], ack width 1 cycle.
- Write addr 0x400, data_i = {8{32'hDEADBEEF}}; then read 0x400 → memory[32] equals the written pattern after the first ack; the second ack returns data_o = {8{32'hDEADBEEF}}.
- LATENCY=1: read 0x0 → ack_o in the cycle after acceptance. enable_i left high through ack → second ack exactly 2 cycles later.
- Drop enable_i after the first cycle of a 10-cycle read → ack still arrives on time with the correct data. Address 0x4020 aliases to line 1 when DEPTH=512.
- Assert rst_i in the 5th WAIT cycle of a write to 0x40 → ack_o never fires, memory[2] unchanged (ECFA pattern), data_o = 0, state IDLE.
- With MEM_LINE_RESPONDER_STATS_EN: 3 reads + 2 writes → rd_count = 3, wr_count = 2. rst_i clears both to 0.
